// File: rtl/quad_gen_pkg.sv
// quad_gen_pkg
//   Shared types and constants for the quadrature generator:
//   FSM state enum, quadrature phase encodings (ab), default widths
//   and a helper that steps the phase one position up or down.
package quad_gen_pkg;

    localparam int QG_WIDTH_DEF = 8;
    localparam int QG_DIV_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT1 = 2'd1,
        WAIT2 = 2'd2
    } qg_state_e;

    // ab encodings in up-count order; down is the reverse walk
    localparam logic [1:0] PH0 = 2'b00;
    localparam logic [1:0] PH1 = 2'b10;
    localparam logic [1:0] PH2 = 2'b11;
    localparam logic [1:0] PH3 = 2'b01;

    function automatic logic [1:0] qg_next_phase(input logic [1:0] ab, input logic up);
        logic [1:0] nxt;
        nxt = ab;
        case (ab)
            PH0:     nxt = up ? PH1 : PH3;
            PH1:     nxt = up ? PH2 : PH0;
            PH2:     nxt = up ? PH3 : PH1;
            default: nxt = up ? PH0 : PH2;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/quad_gen_step_timer.sv
// quad_step_timer
//   Edge-spacing down-counter for quad_gen. Loads a value, counts down
//   one per enabled cycle and holds at zero.
//   Ports:
//     clk, reset   system clock, async active-high reset (count -> 0)
//     i_load       load i_load_val this cycle (wins over i_dec)
//     i_load_val   value to load
//     i_dec        decrement when nonzero
//     o_zero       count is zero
module quad_step_timer #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [DIV_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    localparam logic [DIV_W-1:0] C_ONE = DIV_W'(1);

    logic [DIV_W-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - C_ONE;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/quad_gen.sv
// quad_gen
//   Quadrature waveform generator. Accepts a target position and walks a
//   paired quadrature decoder there, two phase edges per count, with
//   eff_P = max(period,1) clk cycles between edges.
//   Optional build macro: QUAD_GEN_ABORT_EN adds the 'abort' input.
//   Ports:
//     clk, reset   system clock, async active-high reset
//     abort        (QUAD_GEN_ABORT_EN only) stop the move at the next even phase
//     cmd_valid    target command present
//     cmd_ready    idle, command can be accepted
//     cmd_target   requested position
//     period       clk cycles between phase edges (0 treated as 1)
//     a, b         registered quadrature phases
//     position     count the paired decoder holds
//     busy         !cmd_ready
//
//   state | meaning
//   IDLE  | at rest on an even phase, accepting commands
//   WAIT1 | waiting for the counting (odd) edge of a step
//   WAIT2 | waiting for the closing (even) edge of a step
module quad_gen
    import quad_gen_pkg::*;
#(
    parameter int WIDTH = QG_WIDTH_DEF,
    parameter int DIV_W = QG_DIV_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
`ifdef QUAD_GEN_ABORT_EN
    input  logic             abort,
`endif
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_target,
    input  logic [DIV_W-1:0] period,
    output logic             a,
    output logic             b,
    output logic [WIDTH-1:0] position,
    output logic             busy
);

    localparam logic [WIDTH-1:0] C_POS_ONE = WIDTH'(1);
    localparam logic [DIV_W-1:0] C_DIV_ONE = DIV_W'(1);

    qg_state_e        r_state;
    qg_state_e        w_next_state;
    logic [WIDTH-1:0] r_target;
    logic [WIDTH-1:0] r_pos;
    logic [DIV_W-1:0] r_reload;
    logic             r_dir_up;
    logic [1:0]       r_ab;

    logic [WIDTH-1:0] w_diff;
    logic [DIV_W-1:0] w_eff_m1;
    logic             w_accept;
    logic             w_tmr_load;
    logic [DIV_W-1:0] w_tmr_val;
    logic             w_tmr_dec;
    logic             w_tmr_zero;
    logic             w_edge;
    logic             w_count;
    logic             w_abort_now;
    logic             w_abort_hold;

    assign w_diff   = cmd_target - r_pos;
    assign w_eff_m1 = (period == '0) ? '0 : (period - C_DIV_ONE);
    assign w_accept = cmd_valid && (r_state == IDLE);

`ifdef QUAD_GEN_ABORT_EN
    // An abort seen in WAIT2 must survive until the pending edge lands.
    logic r_abort_pend;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_abort_pend <= 1'b0;
        end else if (w_next_state == IDLE) begin
            r_abort_pend <= 1'b0;
        end else if ((r_state == WAIT2) && abort) begin
            r_abort_pend <= 1'b1;
        end
    end

    assign w_abort_now  = abort;
    assign w_abort_hold = abort || r_abort_pend;
`else
    assign w_abort_now  = 1'b0;
    assign w_abort_hold = 1'b0;
`endif

    always_comb begin
        w_next_state = r_state;
        w_tmr_load   = 1'b0;
        w_tmr_val    = r_reload;
        w_tmr_dec    = 1'b0;
        w_edge       = 1'b0;
        w_count      = 1'b0;
        case (r_state)
            IDLE: begin
                // A zero-distance command is consumed without leaving IDLE.
                if (w_accept && (w_diff != '0)) begin
                    w_next_state = WAIT1;
                    w_tmr_load   = 1'b1;
                    w_tmr_val    = w_eff_m1;
                end
            end
            WAIT1: begin
                if (w_abort_now) begin
                    w_next_state = IDLE;
                    w_tmr_load   = 1'b1;
                    w_tmr_val    = '0;
                end else if (w_tmr_zero) begin
                    w_edge       = 1'b1;
                    w_count      = 1'b1;
                    w_tmr_load   = 1'b1;
                    w_next_state = WAIT2;
                end else begin
                    w_tmr_dec = 1'b1;
                end
            end
            WAIT2: begin
                if (w_tmr_zero) begin
                    w_edge = 1'b1;
                    if ((r_pos == r_target) || w_abort_hold) begin
                        w_next_state = IDLE;
                    end else begin
                        w_tmr_load   = 1'b1;
                        w_next_state = WAIT1;
                    end
                end else begin
                    w_tmr_dec = 1'b1;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_target <= '0;
            r_pos    <= '0;
            r_reload <= '0;
            r_dir_up <= 1'b1;
            r_ab     <= PH0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_target <= cmd_target;
                r_reload <= w_eff_m1;
                // Half-range tie (MSB set) resolves downward.
                r_dir_up <= ~w_diff[WIDTH-1];
            end
            if (w_edge) begin
                r_ab <= qg_next_phase(r_ab, r_dir_up);
            end
            if (w_count) begin
                r_pos <= r_dir_up ? (r_pos + C_POS_ONE) : (r_pos - C_POS_ONE);
            end
        end
    end

    quad_step_timer #(
        .DIV_W (DIV_W)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .i_dec      (w_tmr_dec),
        .o_zero     (w_tmr_zero)
    );

    assign a         = r_ab[1];
    assign b         = r_ab[0];
    assign position  = r_pos;
    assign cmd_ready = (r_state == IDLE);
    assign busy      = ~cmd_ready;

endmodule

// File: tb/tb_quad_gen.sv
// tb_quad_gen
//   Randomized self-checking bench for quad_gen. Expected a/b/position/ready
//   at every cycle of a move come from closed-form arithmetic (edges elapsed
//   = t / eff_P); a separate decoder model counts the observed a/b edges.
module tb_quad_gen;

    localparam int W  = 8;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic [W-1:0]  cmd_target = '0;
    logic [DW-1:0] period = '0;
    logic          cmd_ready;
    logic          a;
    logic          b;
    logic [W-1:0]  position;
    logic          busy;
`ifdef QUAD_GEN_ABORT_EN
    logic          abort = 1'b0;
`endif

    always #5 clk = ~clk;

    quad_gen #(
        .WIDTH (W),
        .DIV_W (DW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
`ifdef QUAD_GEN_ABORT_EN
        .abort      (abort),
`endif
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_target (cmd_target),
        .period     (period),
        .a          (a),
        .b          (b),
        .position   (position),
        .busy       (busy)
    );

    int checks = 0;
    int errors = 0;
    int m_pos = 0;
    int m_idx = 0;
    int dec_cnt = 0;
    int last_idx = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [1:0] ab_of(input int idx);
        case (idx & 3)
            0:       return 2'b00;
            1:       return 2'b10;
            2:       return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    function automatic int idx_of(input logic [1:0] ab);
        case (ab)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    // Decoder model: counts on the first edge of each pair (entering an odd phase).
    task automatic dec_sample();
        int idx;
        int d;
        idx = idx_of({a, b});
        d = (idx - last_idx) & 3;
        if (d == 1 && (idx & 1) == 1) dec_cnt = (dec_cnt + 1) & 255;
        if (d == 3 && (idx & 1) == 1) dec_cnt = (dec_cnt - 1) & 255;
        last_idx = idx;
    endtask

    task automatic model_reset();
        m_pos = 0;
        m_idx = 0;
        dec_cnt = 0;
        last_idx = 0;
    endtask

    // Called at a negedge with the block idle.
    task automatic do_move(input int tgt, input int per);
        int p_eff, diff, up, n, total, e, exp_pos, exp_idx;
        p_eff = (per == 0) ? 1 : per;
        diff  = (tgt - m_pos) & 255;
        up    = (diff < 128) ? 1 : 0;
        n     = up ? diff : 256 - diff;
        total = 2 * n * p_eff;
        exp_idx = m_idx;
        check("ready_before", 32'(cmd_ready), 32'd1);
        cmd_valid  = 1'b1;
        cmd_target = W'(tgt);
        period     = DW'(per);
        @(posedge clk);
        #1;
        cmd_valid  = 1'b0;
        cmd_target = W'($urandom);
        period     = DW'($urandom_range(0, 7));
        for (int t = 0; t <= total; t++) begin
            @(negedge clk);
            dec_sample();
            e = t / p_eff;
            if (e > 2 * n) e = 2 * n;
            exp_pos = (up ? (m_pos + (e + 1) / 2) : (m_pos - (e + 1) / 2)) & 255;
            exp_idx = (up ? (m_idx + e) : (m_idx - e)) & 3;
            check("ab", 32'({a, b}), 32'(ab_of(exp_idx)));
            check("position", 32'(position), 32'(exp_pos));
            check("ready", 32'(cmd_ready), 32'(t >= total));
            check("busy", 32'(busy), 32'(t < total));
        end
        m_pos = tgt & 255;
        m_idx = exp_idx;
        check("decoder", 32'(dec_cnt), 32'(m_pos));
        check("rest_even", 32'(m_idx & 1), 32'd0);
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_ab", 32'({a, b}), 32'd0);
        check("rst_pos", 32'(position), 32'd0);
        check("rst_ready", 32'(cmd_ready), 32'd1);

        // Reset in WAIT2 at phase 10
        cmd_valid  = 1'b1;
        cmd_target = 8'd3;
        period     = 16'd4;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (6) @(negedge clk);
        check("pre_rst_ab", 32'({a, b}), 32'(2'b10));
        check("pre_rst_pos", 32'(position), 32'd1);
        reset = 1'b1;
        #1;
        check("async_rst_ab", 32'({a, b}), 32'd0);
        check("async_rst_pos", 32'(position), 32'd0);
        check("async_rst_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        check("post_rst_ab", 32'({a, b}), 32'd0);
        check("post_rst_ready", 32'(cmd_ready), 32'd1);

        // Directed moves from the plan
        do_move(3, 4);
        do_move(8'hFE, int'($urandom_range(0, 3)));
        do_move(8'hFF, 1);
        do_move(1, 0);
        do_move(1, 5);
        do_move((m_pos + 128) & 255, 0);

        // Randomized moves
        for (int i = 0; i < 14; i++) begin
            int off;
            off = int'($urandom_range(0, 24)) - 12;
            do_move((m_pos + off) & 255, int'($urandom_range(0, 4)));
        end

`ifdef QUAD_GEN_ABORT_EN
        begin
            int p0, i0;
            p0 = m_pos;
            i0 = m_idx;
            cmd_valid  = 1'b1;
            cmd_target = W'((p0 + 5) & 255);
            period     = 16'd3;
            @(posedge clk);
            #1;
            cmd_valid = 1'b0;
            repeat (8) begin
                @(negedge clk);
                dec_sample();
            end
            check("abort_mid_ab", 32'({a, b}), 32'(ab_of(i0 + 2)));
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            dec_sample();
            check("abort_ready", 32'(cmd_ready), 32'd1);
            check("abort_pos", 32'(position), 32'((p0 + 1) & 255));
            check("abort_ab", 32'({a, b}), 32'(ab_of(i0 + 2)));
            m_pos = (p0 + 1) & 255;
            m_idx = (i0 + 2) & 3;
            check("abort_decoder", 32'(dec_cnt), 32'(m_pos));
            do_move((m_pos + 3) & 255, 1);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
